bus_initiator: RTL

BUS_INITIATOR -- requirements
Module: bus_initiator

---
 rtl/bus_initiator_pkg.sv | 16 +
 rtl/bus_initiator.sv | 116 +++++++++++
 2 files changed

// File: rtl/bus_initiator_pkg.sv
// Shared types for the bus initiator, future bus slaves and the interconnect.
package bus_initiator_pkg;

    // Transaction phase of a bus master.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } bus_state_e;

    // A word access must sit on a 4-byte boundary.
    function automatic logic addr_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/bus_initiator.sv
// Single-outstanding bus initiator: accepts a command, runs one bus cycle with
// an ack timeout, then holds the response until the consumer takes it.
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int       ADDR_WIDTH = 32,
    parameter int       DATA_WIDTH = 32,
    parameter int       TIMEOUT    = 16,
    parameter logic     ALIGNED    = 1'b1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    // command
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic                  i_req_wnr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    // response
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    // bus
    output logic [ADDR_WIDTH-1:0] o_address,
    output logic                  o_data_valid,
    output logic                  o_wr,
    output logic [DATA_WIDTH-1:0] o_data_out,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_data_ack
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    bus_state_e            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [CNT_W-1:0]      cnt_q;

    logic reject;
    assign reject = (ALIGNED == 1'b1) && addr_misaligned(i_req_addr[1:0]);

    // Transaction FSM; bus fields are cleared whenever the bus cycle ends so
    // they read as zero outside BUS, and the response clears on hand-off.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req_valid) begin
                        if (reject) begin
                            state_q <= RESP;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state_q <= BUS;
                            addr_q  <= i_req_addr;
                            wr_q    <= i_req_wnr;
                            wdata_q <= i_req_wdata;
                            cnt_q   <= '0;
                        end
                    end
                end
                BUS: begin
                    // An ack on the last allowed cycle still wins over timeout.
                    if (i_data_ack) begin
                        state_q <= RESP;
                        rdata_q <= wr_q ? '0 : i_data_in;
                        err_q   <= 1'b0;
                        addr_q  <= '0;
                        wr_q    <= 1'b0;
                        wdata_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= RESP;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        addr_q  <= '0;
                        wr_q    <= 1'b0;
                        wdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        state_q <= IDLE;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_req_ready  = (state_q == IDLE);
    assign o_data_valid = (state_q == BUS);
    assign o_rsp_valid  = (state_q == RESP);
    assign o_address    = addr_q;
    assign o_wr         = wr_q;
    assign o_data_out   = wdata_q;
    assign o_rsp_rdata  = rdata_q;
    assign o_rsp_err    = err_q;

endmodule
